axil_regbank: RTL

AXIL_REGBANK -- requirements
Module: axil_regbank

---
 rtl/axil_regbank.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave register bank with NUM_REGS data-wide registers.
// Optional build macro AXIL_REGBANK_STATUS_EN: the upper half of the register
// space (index >= NUM_REGS/2) becomes read-only and reads the status_in slices.
module axil_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS           = 8
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  // write response channel
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  // user side
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned OFFS  = $clog2(SW);
  localparam int unsigned IDX_W = AW - OFFS;
`ifdef AXIL_REGBANK_STATUS_EN
  localparam int unsigned RW_REGS = NUM_REGS / 2;
`else
  localparam int unsigned RW_REGS = NUM_REGS;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Holding registers and response state
  logic                r_init;
  logic                r_aw_held;
  logic [IDX_W-1:0]    r_aw_idx;
  logic                r_w_held;
  logic [DW-1:0]       r_w_data;
  logic [SW-1:0]       r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [DW-1:0]       r_rdata;
  logic [DW-1:0]       r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_commit;
  logic                w_wr_ok;
  logic [IDX_W-1:0]    w_ar_idx;
  logic [DW-1:0]       w_rd_data;
  logic [1:0]          w_rd_resp;
  logic                w_unused;

  // Ready/handshake decode; r_init keeps READY low until the first edge after reset
  assign S_AXI_AWREADY = r_init & ~r_aw_held & ~r_bvalid;
  assign S_AXI_WREADY  = r_init & ~r_w_held & ~r_bvalid;
  assign S_AXI_ARREADY = r_init & ~r_rvalid;
  assign w_aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs        = S_AXI_WVALID & S_AXI_WREADY;
  assign w_ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_commit      = r_aw_held & r_w_held;
  assign w_wr_ok       = (32'(r_aw_idx) < RW_REGS);
  assign w_ar_idx      = S_AXI_ARADDR[AW-1:OFFS];

  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign reg_wr_pulse  = r_wr_pulse;

  // Byte-offset address bits and (in the default build) status_in are don't-care
  assign w_unused = ^{status_in, S_AXI_AWADDR[OFFS-1:0], S_AXI_ARADDR[OFFS-1:0]};

  // Post-reset enable for the READY outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // Write-address holding register; only the register index is kept
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_held <= 1'b1;
      r_aw_idx  <= S_AXI_AWADDR[AW-1:OFFS];
    end
  end

  // Write-data holding register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_w_held <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
    end else if (w_commit) begin
      r_w_held <= 1'b0;
    end else if (w_w_hs) begin
      r_w_held <= 1'b1;
      r_w_data <= S_AXI_WDATA;
      r_w_strb <= S_AXI_WSTRB;
    end
  end

  // Register file update with per-byte strobes on a committed in-range write
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (r_aw_idx == IDX_W'(k)) begin
          for (int unsigned b = 0; b < SW; b++) begin
            if (r_w_strb[b]) r_regs[k][b*8 +: 8] <= r_w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // One-cycle write strobe, aligned with the register update
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_wr_ok) begin
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          if (r_aw_idx == IDX_W'(k)) r_wr_pulse[k] <= 1'b1;
        end
      end
    end
  end

  // Write response: raised on commit, held until BREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && S_AXI_BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read mux on the incoming AR address; pre-write register values are seen on a
  // commit edge because the mux reads the flops before they update
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (w_ar_idx == IDX_W'(k)) begin
        w_rd_resp = RESP_OKAY;
`ifdef AXIL_REGBANK_STATUS_EN
        if (k >= RW_REGS) w_rd_data = status_in[k*DW +: DW];
        else              w_rd_data = r_regs[k];
`else
        w_rd_data = r_regs[k];
`endif
      end
    end
  end

  // Read response: captured at the AR handshake, held until RREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_resp;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Flat register view; read-only status slots show zero
  always_comb begin
    reg_out = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
`ifdef AXIL_REGBANK_STATUS_EN
      if (k < RW_REGS) reg_out[k*DW +: DW] = r_regs[k];
`else
      reg_out[k*DW +: DW] = r_regs[k];
`endif
    end
  end

endmodule
